// File: rtl/vx_int_unit_pipe.sv
// ============================================================================
// Module   : vx_int_unit_pipe
// Brief    : SIMD integer ALU / branch unit with an elastic PIPE_STAGES-deep
//            pipeline. Optional MIN/MAX ops enabled by INT_UNIT_MINMAX_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vx_int_unit_pipe #(
    parameter int NUM_LANES   = 4,
    parameter int XLEN        = 32,
    parameter int PIPE_STAGES = 2,
    parameter int WID_W       = 2,
    parameter int TAG_W       = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [3:0]                in_op,
    input  logic                      in_is_br,
    input  logic                      in_use_pc,
    input  logic                      in_use_imm,
    input  logic                      in_eop,
    input  logic [WID_W-1:0]          in_wid,
    input  logic [NUM_LANES-1:0]      in_tmask,
    input  logic [TAG_W-1:0]          in_tag,
    input  logic [XLEN-1:0]           in_pc,
    input  logic [XLEN-1:0]           in_imm,
    input  logic [NUM_LANES*XLEN-1:0] in_rs1,
    input  logic [NUM_LANES*XLEN-1:0] in_rs2,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NUM_LANES*XLEN-1:0] out_data,
    output logic [NUM_LANES-1:0]      out_tmask,
    output logic [WID_W-1:0]          out_wid,
    output logic [TAG_W-1:0]          out_tag,
    output logic [XLEN-1:0]           out_pc,
    output logic                      out_eop,
    output logic                      br_valid,
    output logic [WID_W-1:0]          br_wid,
    output logic                      br_taken,
    output logic [XLEN-1:0]           br_dest
);

    localparam int c_shamt_w = $clog2(XLEN);
    localparam int c_lane_w  = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int c_last    = PIPE_STAGES - 1;
    localparam logic [XLEN-1:0] c_align_mask = {{(XLEN-1){1'b1}}, 1'b0};

    typedef struct packed {
        logic [NUM_LANES*XLEN-1:0] data;
        logic [NUM_LANES-1:0]      tmask;
        logic [WID_W-1:0]          wid;
        logic [TAG_W-1:0]          tag;
        logic [XLEN-1:0]           pc;
        logic                      eop;
        logic                      is_br;
        logic                      taken;
        logic [XLEN-1:0]           dest;
    } stage_t;

    function automatic logic [XLEN-1:0] f_alu(input logic [3:0] op,
                                              input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b,
                                              input logic [XLEN-1:0] imm);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            4'd3:    return {{(XLEN-1){1'b0}}, a < b};
            4'd4:    return a & b;
            4'd5:    return a | b;
            4'd6:    return a ^ b;
            4'd7:    return a << b[c_shamt_w-1:0];
            4'd8:    return a >> b[c_shamt_w-1:0];
            4'd9:    return XLEN'($signed(a) >>> b[c_shamt_w-1:0]);
            4'd10:   return imm;
`ifdef INT_UNIT_MINMAX_EN
            4'd12:   return ($signed(a) < $signed(b)) ? a : b;
            4'd13:   return ($signed(a) < $signed(b)) ? b : a;
            4'd14:   return (a < b) ? a : b;
            4'd15:   return (a < b) ? b : a;
`endif
            default: return '0;
        endcase
    endfunction

    logic [c_lane_w-1:0]    w_lane;
    logic [XLEN-1:0]        w_br_a;
    logic [XLEN-1:0]        w_br_b;
    logic                   w_br_taken;
    logic [XLEN-1:0]        w_br_dest;
    logic [XLEN-1:0]        w_link;
    stage_t                 w_s0;
    stage_t                 r_stage [PIPE_STAGES];
    logic [PIPE_STAGES-1:0] r_valid;
    logic [PIPE_STAGES-1:0] w_ready;
    logic [PIPE_STAGES-1:0] w_prev_valid;
    logic                   w_out_fire;
    logic                   r_br_valid;
    logic [WID_W-1:0]       r_br_wid;
    logic                   r_br_taken;
    logic [XLEN-1:0]        r_br_dest;

    // Branch lane is the lowest active lane; an empty mask falls back to lane 0.
    always_comb begin
        w_lane = '0;
        for (int l = NUM_LANES - 1; l >= 0; l--) begin
            if (in_tmask[l]) w_lane = c_lane_w'(l);
        end
        w_br_a = in_rs1[w_lane*XLEN +: XLEN];
        w_br_b = in_rs2[w_lane*XLEN +: XLEN];
    end

    always_comb begin
        w_br_taken = 1'b0;
        w_br_dest  = in_pc + in_imm;
        w_link     = '0;
        case (in_op)
            4'd0: w_br_taken = (w_br_a == w_br_b);
            4'd1: w_br_taken = (w_br_a != w_br_b);
            4'd2: w_br_taken = ($signed(w_br_a) <  $signed(w_br_b));
            4'd3: w_br_taken = ($signed(w_br_a) >= $signed(w_br_b));
            4'd4: w_br_taken = (w_br_a <  w_br_b);
            4'd5: w_br_taken = (w_br_a >= w_br_b);
            4'd6: begin
                w_br_taken = 1'b1;
                w_link     = in_pc + XLEN'(4);
            end
            4'd7: begin
                w_br_taken = 1'b1;
                w_br_dest  = (w_br_a + in_imm) & c_align_mask;
                w_link     = in_pc + XLEN'(4);
            end
            default: ;
        endcase
    end

    always_comb begin
        w_s0       = '0;
        w_s0.tmask = in_tmask;
        w_s0.wid   = in_wid;
        w_s0.tag   = in_tag;
        w_s0.pc    = in_pc;
        w_s0.eop   = in_eop;
        w_s0.is_br = in_is_br;
        w_s0.taken = w_br_taken;
        w_s0.dest  = w_br_dest;
        for (int l = 0; l < NUM_LANES; l++) begin
            if (in_is_br) begin
                w_s0.data[l*XLEN +: XLEN] = w_link;
            end else begin
                w_s0.data[l*XLEN +: XLEN] = f_alu(in_op,
                    in_use_pc  ? in_pc  : in_rs1[l*XLEN +: XLEN],
                    in_use_imm ? in_imm : in_rs2[l*XLEN +: XLEN],
                    in_imm);
            end
        end
    end

    // A stage may load whenever any stage at or after it has a hole, so
    // bubbles collapse without a combinational ready chain.
    for (genvar s = 0; s < PIPE_STAGES; s++) begin : g_stage
        assign w_ready[s] = out_ready | ~(&r_valid[c_last:s]);
        if (s == 0) begin : g_head
            assign w_prev_valid[s] = in_valid;
            always_ff @(posedge clk) begin
                if (w_ready[s] && in_valid) r_stage[s] <= w_s0;
            end
        end else begin : g_body
            assign w_prev_valid[s] = r_valid[s-1];
            always_ff @(posedge clk) begin
                if (w_ready[s] && r_valid[s-1]) r_stage[s] <= r_stage[s-1];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= '0;
        end else begin
            r_valid <= (w_ready & w_prev_valid) | (~w_ready & r_valid);
        end
    end

    assign w_out_fire = r_valid[c_last] & out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_br_valid <= 1'b0;
            r_br_wid   <= '0;
            r_br_taken <= 1'b0;
            r_br_dest  <= '0;
        end else begin
            r_br_valid <= w_out_fire & r_stage[c_last].is_br & r_stage[c_last].eop;
            if (w_out_fire && r_stage[c_last].is_br && r_stage[c_last].eop) begin
                r_br_wid   <= r_stage[c_last].wid;
                r_br_taken <= r_stage[c_last].taken;
                r_br_dest  <= r_stage[c_last].dest;
            end
        end
    end

    assign in_ready  = w_ready[0];
    assign out_valid = r_valid[c_last];
    assign out_data  = r_stage[c_last].data;
    assign out_tmask = r_stage[c_last].tmask;
    assign out_wid   = r_stage[c_last].wid;
    assign out_tag   = r_stage[c_last].tag;
    assign out_pc    = r_stage[c_last].pc;
    assign out_eop   = r_stage[c_last].eop;
    assign br_valid  = r_br_valid;
    assign br_wid    = r_br_wid;
    assign br_taken  = r_br_taken;
    assign br_dest   = r_br_dest;

endmodule

`default_nettype wire

// File: tb/tb_vx_int_unit_pipe.sv
// ============================================================================
// Module   : tb_vx_int_unit_pipe
// Brief    : Directed self-checking bench for vx_int_unit_pipe (default params).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vx_int_unit_pipe;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid, in_ready, in_is_br, in_use_pc, in_use_imm, in_eop;
    logic [3:0]   in_op, in_tmask;
    logic [1:0]   in_wid;
    logic [7:0]   in_tag;
    logic [31:0]  in_pc, in_imm;
    logic [127:0] in_rs1, in_rs2;
    logic         out_valid, out_ready, out_eop;
    logic [127:0] out_data;
    logic [3:0]   out_tmask;
    logic [1:0]   out_wid;
    logic [7:0]   out_tag;
    logic [31:0]  out_pc;
    logic         br_valid, br_taken;
    logic [1:0]   br_wid;
    logic [31:0]  br_dest;

    int checks = 0;
    int errors = 0;

    logic [127:0] g_data;
    logic [7:0]   g_tag;
    logic [3:0]   g_tmask;
    logic         g_brv, g_brv2, g_taken;
    logic [1:0]   g_brwid;
    logic [31:0]  g_dest, g_dest2;
    int           g_lat;
    logic [7:0]   tag_n = 8'h10;

    always #5 clk = ~clk;

    vx_int_unit_pipe dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_is_br(in_is_br), .in_use_pc(in_use_pc), .in_use_imm(in_use_imm),
        .in_eop(in_eop), .in_wid(in_wid), .in_tmask(in_tmask), .in_tag(in_tag),
        .in_pc(in_pc), .in_imm(in_imm), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_tmask(out_tmask), .out_wid(out_wid), .out_tag(out_tag),
        .out_pc(out_pc), .out_eop(out_eop),
        .br_valid(br_valid), .br_wid(br_wid), .br_taken(br_taken), .br_dest(br_dest)
    );

    function automatic logic [127:0] rep(input logic [31:0] x);
        return {4{x}};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One isolated request with out_ready high; records latency, result and branch pulse.
    task automatic issue(input logic [3:0] op, input logic is_br, input logic use_pc,
                         input logic use_imm, input logic [3:0] tmask,
                         input logic [31:0] pc, input logic [31:0] imm,
                         input logic [127:0] rs1, input logic [127:0] rs2);
        @(negedge clk);
        in_op = op; in_is_br = is_br; in_use_pc = use_pc; in_use_imm = use_imm;
        in_tmask = tmask; in_pc = pc; in_imm = imm; in_rs1 = rs1; in_rs2 = rs2;
        in_eop = 1'b1; tag_n = tag_n + 8'd1; in_tag = tag_n; in_wid = tag_n[1:0];
        out_ready = 1'b1; in_valid = 1'b1;
        #1 check("in_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        g_lat = 1;
        while (!out_valid && g_lat < 10) begin
            @(posedge clk); #1;
            g_lat++;
        end
        g_data = out_data; g_tag = out_tag; g_tmask = out_tmask;
        @(posedge clk); #1;
        g_brv = br_valid; g_taken = br_taken; g_dest = br_dest; g_brwid = br_wid;
        @(posedge clk); #1;
        g_brv2 = br_valid; g_dest2 = br_dest;
    endtask

    initial begin
        logic [127:0] exp_min, exp_maxu;
        logic         in_fire, out_fire, seen;
        logic [127:0] cap_data;
        logic [7:0]   cap_tag;
        int           sent, recv, cyc;

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_op = '0; in_is_br = 0; in_use_pc = 0; in_use_imm = 0; in_eop = 0;
        in_wid = '0; in_tmask = '0; in_tag = '0; in_pc = '0; in_imm = '0;
        in_rs1 = '0; in_rs2 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_br_valid", br_valid, 0);
        check("rst_br_taken", br_taken, 0);
        check("rst_br_dest", br_dest, 0);
        check("rst_br_wid", br_wid, 0);
        @(negedge clk) reset = 1'b0;
        #1 check("rst_in_ready", in_ready, 1);

        issue(4'd0, 0, 0, 0, 4'hF, 32'h0, 32'h0, rep(32'd5), rep(32'd7));
        check("add_latency", g_lat, 2);
        check("add_data", g_data, rep(32'd12));
        check("add_tag", g_tag, tag_n);
        check("add_no_br", g_brv, 0);

        issue(4'd9, 0, 0, 0, 4'hF, 32'h0, 32'h0, rep(32'h80000000), rep(32'd4));
        check("sra", g_data, rep(32'hF8000000));
        issue(4'd8, 0, 0, 0, 4'hF, 32'h0, 32'h0, rep(32'h80000000), rep(32'd4));
        check("srl", g_data, rep(32'h08000000));
        issue(4'd2, 0, 0, 0, 4'hF, 32'h0, 32'h0, rep(32'hFFFFFFFF), rep(32'd1));
        check("slt", g_data, rep(32'd1));
        issue(4'd3, 0, 0, 0, 4'hF, 32'h0, 32'h0, rep(32'hFFFFFFFF), rep(32'd1));
        check("sltu", g_data, rep(32'd0));
        issue(4'd0, 0, 1, 1, 4'hF, 32'h100, 32'h10, rep(32'd0), rep(32'd0));
        check("pc_plus_imm", g_data, rep(32'h110));
        issue(4'd10, 0, 0, 1, 4'hF, 32'h0, 32'h12345000, rep(32'd9), rep(32'd9));
        check("lui", g_data, rep(32'h12345000));
        issue(4'd11, 0, 0, 0, 4'hF, 32'h0, 32'h0, rep(32'd9), rep(32'd3));
        check("reserved", g_data, rep(32'd0));
        issue(4'd1, 0, 0, 0, 4'hF, 32'h0, 32'h0, rep(32'd3), rep(32'd5));
        check("sub", g_data, rep(32'hFFFFFFFE));

        // BLT on lane 2; lane 0 alone would be not-taken
        issue(4'd2, 1, 0, 0, 4'b0100, 32'h100, 32'h20,
              {32'h0, 32'hFFFFFFFD, 32'h0, 32'h5}, {32'h0, 32'h2, 32'h0, 32'h1});
        check("blt_brv", g_brv, 1);
        check("blt_taken", g_taken, 1);
        check("blt_dest", g_dest, 32'h120);
        check("blt_wid", g_brwid, tag_n[1:0]);
        check("blt_data", g_data, '0);
        check("blt_tmask", g_tmask, 4'b0100);
        check("blt_pulse_end", g_brv2, 0);
        check("blt_dest_held", g_dest2, 32'h120);

        issue(4'd7, 1, 0, 0, 4'hF, 32'h200, 32'h4, rep(32'h1001), rep(32'd0));
        check("jalr_taken", g_taken, 1);
        check("jalr_dest", g_dest, 32'h1004);
        check("jalr_data", g_data, rep(32'h204));

        issue(4'd0, 1, 0, 0, 4'b0000, 32'h300, 32'hFFFFFFF0,
              {32'h1, 32'h2, 32'h3, 32'h7}, {32'h9, 32'h9, 32'h9, 32'h7});
        check("beq_t0_brv", g_brv, 1);
        check("beq_t0_taken", g_taken, 1);
        check("beq_t0_dest", g_dest, 32'h2F0);

        issue(4'd5, 1, 0, 0, 4'hF, 32'h40, 32'h8, rep(32'd1), rep(32'd2));
        check("bgeu_taken", g_taken, 0);
        check("bgeu_dest", g_dest, 32'h48);

`ifdef INT_UNIT_MINMAX_EN
        exp_min  = rep(32'hFFFFFFFB);
        exp_maxu = rep(32'hFFFFFFFF);
`else
        exp_min  = '0;
        exp_maxu = '0;
`endif
        issue(4'd12, 0, 0, 0, 4'hF, 32'h0, 32'h0, rep(32'hFFFFFFFB), rep(32'd3));
        check("min", g_data, exp_min);
        issue(4'd15, 0, 0, 0, 4'hF, 32'h0, 32'h0, rep(32'hFFFFFFFF), rep(32'd1));
        check("maxu", g_data, exp_maxu);

        // Streaming under random backpressure: result i = i + 10*i, tag 0x40+i
        sent = 0; recv = 0; cyc = 0;
        in_op = 4'd0; in_is_br = 0; in_use_pc = 0; in_use_imm = 0; in_tmask = 4'hF;
        while (recv < 8 && cyc < 400) begin
            @(negedge clk);
            out_ready = 1'($urandom_range(0, 1));
            if (sent < 8) begin
                in_valid = 1'b1;
                in_rs1 = rep(32'(sent));
                in_rs2 = rep(32'(10 * sent));
                in_tag = 8'h40 + 8'(sent);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            in_fire  = in_valid && in_ready;
            out_fire = out_valid && out_ready;
            cap_data = out_data;
            cap_tag  = out_tag;
            @(posedge clk);
            cyc++;
            if (out_fire) begin
                if (recv < 8) begin
                    check("stream_data", cap_data, rep(32'(11 * recv)));
                    check("stream_tag", cap_tag, 8'h40 + 8'(recv));
                end
                recv++;
            end
            if (in_fire) sent++;
        end
        check("stream_count", recv, 8);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        seen = 1'b0;
        repeat (4) begin
            #1 seen = seen | out_valid;
            @(negedge clk);
        end
        check("stream_no_dup", seen, 0);

        // Reset with the pipeline full of JALs and a third one waiting
        in_op = 4'd6; in_is_br = 1; in_eop = 1; in_pc = 32'h500; in_imm = 32'h8;
        out_ready = 1'b0; in_valid = 1'b1;
        repeat (3) @(negedge clk);
        #1 check("mid_full", out_valid, 1);
        reset = 1'b1;
        #1 check("mid_async_clear", out_valid, 0);
        @(negedge clk);
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        #1 check("mid_in_ready", in_ready, 1);
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            #1 seen = seen | out_valid | br_valid;
        end
        check("mid_no_output", seen, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
